// File: rtl/sha256_padder_if.sv
// sha256_padder_if
//   Groups the message-input and block-output handshakes of the SHA-256
//   padder.
//   Message side : start, in_valid/in_ready, in_data, in_nbytes, in_last
//   Block side   : blk_valid/blk_ready, blk_words (w[0] is blk_words[0]),
//                  blk_first, blk_last
//   master : the producer of messages and consumer of blocks
//   slave  : the padder itself
interface sha256_padder_if;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic [2:0]        in_nbytes;
    logic              in_last;
    logic              blk_valid;
    logic              blk_ready;
    logic [15:0][31:0] blk_words;
    logic              blk_first;
    logic              blk_last;

    modport master (
        output start, in_valid, in_data, in_nbytes, in_last, blk_ready,
        input  in_ready, blk_valid, blk_words, blk_first, blk_last
    );

    modport slave (
        input  start, in_valid, in_data, in_nbytes, in_last, blk_ready,
        output in_ready, blk_valid, blk_words, blk_first, blk_last
    );
endinterface

// File: rtl/sha256_padder.sv
// sha256_padder
//   Collects big-endian 32-bit message words into a 16-word buffer and emits
//   SHA-256 padded 512-bit blocks: 0x80 marker after the last byte, zero fill,
//   and a 64-bit big-endian bit length in w[14..15]. When the marker or the
//   length does not fit, one extra block is produced.
//   Ports:
//     clk   - single clock, rising edge
//     reset - synchronous, active-high
//     bus   - sha256_padder_if.slave (message input, block output)
//   Parameter LEN_W: width of the message byte counter (wraps modulo 2^LEN_W).
module sha256_padder #(
    parameter int unsigned LEN_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    sha256_padder_if.slave     bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        PAD   = 3'd2,
        EMIT  = 3'd3,
        EXTRA = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [15:0][31:0] w;
    logic [4:0]        idx;          // next word slot, 0..16
    logic [LEN_W-1:0]  byte_cnt;
    logic [2:0]        last_nb;      // in_nbytes of the final message word
    logic              first;
    logic              last_blk;
    logic              pend_len;
    logic              pend_marker;

    logic              in_ready_c;
    logic              blk_valid_c;
    logic [63:0]       bit_len;
    logic [4:0]        mark_idx;
    logic [31:0]       last_word;
    logic [31:0]       mark_word;

    function automatic logic [31:0] keep_mask(input logic [2:0] nb);
        case (nb)
            3'd0:    keep_mask = '0;
            3'd1:    keep_mask = 32'hFF00_0000;
            3'd2:    keep_mask = 32'hFFFF_0000;
            3'd3:    keep_mask = 32'hFFFF_FF00;
            default: keep_mask = '1;
        endcase
    endfunction

    // Marker lands inside the last stored word (slot idx-1) unless that word
    // was full, in which case it starts the following slot (which may be 16).
    always_comb begin
        bit_len   = 64'(byte_cnt) << 3;
        last_word = w[idx[3:0] - 4'd1];
        if (last_nb >= 3'd4) begin
            mark_idx  = idx;
            mark_word = 32'h8000_0000;
        end else begin
            mark_idx = idx - 5'd1;
            case (last_nb)
                3'd1:    mark_word = {last_word[31:24], 24'h80_0000};
                3'd2:    mark_word = {last_word[31:16], 16'h8000};
                3'd3:    mark_word = {last_word[31:8],  8'h80};
                default: mark_word = 32'h8000_0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        blk_valid_c = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    if (bus.in_last) begin
                        state_nxt = PAD;
                    end else if (idx == 5'd15) begin
                        state_nxt = EMIT;
                    end
                end
            end
            PAD: begin
                state_nxt = EMIT;
            end
            EMIT: begin
                blk_valid_c = 1'b1;
                if (bus.blk_ready) begin
                    if (last_blk) begin
                        state_nxt = IDLE;
                    end else if (pend_len || pend_marker) begin
                        state_nxt = EXTRA;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            EXTRA: begin
                state_nxt = EMIT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w           <= '0;
            idx         <= '0;
            byte_cnt    <= '0;
            last_nb     <= '0;
            first       <= 1'b0;
            last_blk    <= 1'b0;
            pend_len    <= 1'b0;
            pend_marker <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx         <= '0;
                        byte_cnt    <= '0;
                        first       <= 1'b1;
                        pend_len    <= 1'b0;
                        pend_marker <= 1'b0;
                    end
                end
                FILL: begin
                    if (bus.in_valid) begin
                        w[idx[3:0]] <= bus.in_data & keep_mask(bus.in_nbytes);
                        idx         <= idx + 5'd1;
                        byte_cnt    <= byte_cnt + LEN_W'(bus.in_nbytes);
                        last_nb     <= bus.in_nbytes;
                        if (!bus.in_last && idx == 5'd15) begin
                            last_blk <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    // Stale words from an earlier message may sit above the
                    // marker, so everything past it is cleared explicitly.
                    for (int unsigned i = 0; i < 16; i++) begin
                        if (32'(mark_idx) == i) begin
                            w[i] <= mark_word;
                        end else if (32'(mark_idx) < i) begin
                            w[i] <= '0;
                        end
                    end
                    if (mark_idx <= 5'd13) begin
                        w[14]    <= bit_len[63:32];
                        w[15]    <= bit_len[31:0];
                        last_blk <= 1'b1;
                    end else if (mark_idx <= 5'd15) begin
                        last_blk <= 1'b0;
                        pend_len <= 1'b1;
                    end else begin
                        last_blk    <= 1'b0;
                        pend_marker <= 1'b1;
                    end
                end
                EMIT: begin
                    if (bus.blk_ready) begin
                        first <= 1'b0;
                        if (!last_blk && !pend_len && !pend_marker) begin
                            w   <= '0;
                            idx <= '0;
                        end
                    end
                end
                EXTRA: begin
                    w           <= '0;
                    w[0]        <= pend_marker ? 32'h8000_0000 : 32'h0;
                    w[14]       <= bit_len[63:32];
                    w[15]       <= bit_len[31:0];
                    last_blk    <= 1'b1;
                    pend_len    <= 1'b0;
                    pend_marker <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.blk_valid = blk_valid_c;
    assign bus.blk_words = w;
    assign bus.blk_first = blk_valid_c & first;
    assign bus.blk_last  = blk_valid_c & last_blk;

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder
//   Directed messages are fed word by word; a byte-level reference padder
//   (append 0x80, zero to 56 mod 64, append 64-bit bit length) predicts the
//   blocks, and a negedge compare process checks every cycle a block is
//   offered. Literal expectations pin the reference for the known vectors.
module tb_sha256_padder;

    typedef struct {
        logic [15:0][31:0] w;
        logic              first;
        logic              last;
    } blk_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   cyc;
    int   evt_cyc;
    int   evt_lat;
    bit   prev_valid;

    byte unsigned msg[$];
    blk_t         exp_q[$];

    sha256_padder_if bus();

    sha256_padder #(.LEN_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference padding on the raw byte stream.
    task automatic model_push(output int unsigned nblk);
        byte unsigned p[$];
        logic [63:0]  bits;
        blk_t         b;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        nblk = p.size() / 64;
        for (int unsigned bi = 0; bi < nblk; bi++) begin
            for (int unsigned j = 0; j < 16; j++) begin
                b.w[j] = {p[64*bi+4*j], p[64*bi+4*j+1], p[64*bi+4*j+2], p[64*bi+4*j+3]};
            end
            b.first = (bi == 0);
            b.last  = (bi == nblk - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic mk_msg(input int unsigned n, input logic [7:0] seed);
        msg.delete();
        for (int unsigned i = 0; i < n; i++) msg.push_back(seed + 8'(i));
    endtask

    task automatic wait_accept(input string nm);
        bit rdy;
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s accept timeout: in_ready=%0b required 1", nm, bus.in_ready);
        end
    endtask

    // Feeds msg[]; bytes past in_nbytes carry the fill pattern.
    task automatic send_msg(input string nm, input bit bp, input logic [7:0] fill);
        int unsigned      n;
        int unsigned      nw;
        int unsigned      nb;
        logic [31:0]      d;
        logic [15:0][31:0] snap;
        logic             sf;
        logic             sl;
        bit               found;
        n  = msg.size();
        nw = (n == 0) ? 1 : (n + 3) / 4;
        bus.blk_ready = bp ? 1'b0 : 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int unsigned wi = 0; wi < nw; wi++) begin
            nb = (n - 4*wi >= 4) ? 4 : n - 4*wi;
            for (int unsigned j = 0; j < 4; j++) begin
                d[31-8*j -: 8] = (j < nb) ? msg[4*wi+j] : fill;
            end
            bus.in_valid  = 1'b1;
            bus.in_data   = d;
            bus.in_nbytes = 3'(nb);
            bus.in_last   = (wi == nw - 1);
            wait_accept(nm);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (bp) begin
            found = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (bus.blk_valid) begin
                    found = 1'b1;
                    break;
                end
            end
            tests++;
            if (!found) begin
                fails++;
                $display("FAIL %s stall: blk_valid=0 required 1", nm);
            end
            snap = bus.blk_words;
            sf   = bus.blk_first;
            sl   = bus.blk_last;
            for (int k = 0; k < 5; k++) begin
                if (k > 0) @(negedge clk);
                tests++;
                if (!bus.blk_valid || bus.in_ready || bus.blk_words !== snap ||
                    bus.blk_first !== sf || bus.blk_last !== sl) begin
                    fails++;
                    $display("FAIL %s hold cycle %0d: valid=%0b in_ready=%0b first=%0b last=%0b w0=%h required valid=1 in_ready=0 first=%0b last=%0b w0=%h",
                             nm, k, bus.blk_valid, bus.in_ready, bus.blk_first, bus.blk_last,
                             bus.blk_words[0], sf, sl, snap[0]);
                end
            end
            @(posedge clk);
            #1 bus.blk_ready = 1'b1;
        end
        found = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL %s drain timeout: %0d blocks outstanding, required 0", nm, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Per-cycle compare of offered blocks against the reference queue.
    always @(negedge clk) begin
        blk_t e;
        int   k;
        cyc++;
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                evt_cyc = cyc;
                evt_lat = bus.in_last ? 2 : 1;
            end
            if (bus.blk_valid) begin
                if (!prev_valid) begin
                    tests++;
                    if (cyc - evt_cyc != evt_lat) begin
                        fails++;
                        $display("FAIL latency: got %0d cycles required %0d", cyc - evt_cyc, evt_lat);
                    end
                end
                tests++;
                if (bus.in_ready) begin
                    fails++;
                    $display("FAIL in_ready during block: got 1 required 0");
                end
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected block: w0=%h first=%0b last=%0b required none",
                             bus.blk_words[0], bus.blk_first, bus.blk_last);
                end else begin
                    e = exp_q[0];
                    if (bus.blk_words !== e.w || bus.blk_first !== e.first || bus.blk_last !== e.last) begin
                        fails++;
                        k = 0;
                        for (int j = 15; j >= 0; j--) if (bus.blk_words[j] !== e.w[j]) k = j;
                        $display("FAIL block: first=%0b last=%0b w[%0d]=%h required first=%0b last=%0b w[%0d]=%h",
                                 bus.blk_first, bus.blk_last, k, bus.blk_words[k], e.first, e.last, k, e.w[k]);
                    end
                    if (bus.blk_ready) begin
                        void'(exp_q.pop_front());
                        evt_cyc = cyc;
                        evt_lat = 2;
                    end
                end
            end
            prev_valid = bus.blk_valid;
        end
    end

    initial begin
        int unsigned nblk;
        int unsigned base;
        tests         = 0;
        fails         = 0;
        cyc           = 0;
        evt_cyc       = 0;
        evt_lat       = 0;
        prev_valid    = 1'b0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_nbytes = '0;
        bus.in_last   = 1'b0;
        bus.blk_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.in_ready || bus.blk_valid || bus.blk_first || bus.blk_last || bus.blk_words !== '0) begin
            fails++;
            $display("FAIL reset state: in_ready=%0b blk_valid=%0b first=%0b last=%0b w0=%h required all zero",
                     bus.in_ready, bus.blk_valid, bus.blk_first, bus.blk_last, bus.blk_words[0]);
        end

        // "abc"
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        base = exp_q.size();
        model_push(nblk);
        pin("abc w0",  exp_q[base].w[0],  32'h6162_6380);
        pin("abc w15", exp_q[base].w[15], 32'h0000_0018);
        send_msg("abc", 1'b0, 8'h00);

        // empty message
        msg.delete();
        base = exp_q.size();
        model_push(nblk);
        pin("empty w0", exp_q[base].w[0], 32'h8000_0000);
        send_msg("empty", 1'b0, 8'h5A);

        // 56 bytes: marker in w14, length in an extra block
        mk_msg(56, 8'h10);
        base = exp_q.size();
        model_push(nblk);
        pin("m56 nblk",   32'(nblk),              32'd2);
        pin("m56 b1 w14", exp_q[base].w[14],      32'h8000_0000);
        pin("m56 b2 w15", exp_q[base+1].w[15],    32'h0000_01C0);
        send_msg("m56", 1'b0, 8'hA5);

        // 64 bytes: marker starts the extra block
        mk_msg(64, 8'h40);
        base = exp_q.size();
        model_push(nblk);
        pin("m64 b2 w0",  exp_q[base+1].w[0],  32'h8000_0000);
        pin("m64 b2 w15", exp_q[base+1].w[15], 32'h0000_0200);
        send_msg("m64", 1'b0, 8'hA5);

        // marker in w15, marker in w13 with length, short and multi-block
        mk_msg(60, 8'h01);  model_push(nblk); send_msg("m60",  1'b0, 8'hA5);
        mk_msg(55, 8'h22);  model_push(nblk); send_msg("m55",  1'b0, 8'hC3);
        mk_msg(5,  8'h77);  model_push(nblk); send_msg("m5",   1'b0, 8'hFF);
        mk_msg(130, 8'h03); model_push(nblk); send_msg("m130", 1'b0, 8'hEE);
        mk_msg(120, 8'h90); model_push(nblk); send_msg("m120", 1'b0, 8'h11);

        // backpressure: ready held low for five cycles of a pending block
        mk_msg(3, 8'h61);   model_push(nblk); send_msg("bp",   1'b1, 8'h00);

        // reset after five words of FILL
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 32'hDEAD_0000 + 32'(i);
            bus.in_nbytes = 3'd4;
            bus.in_last   = 1'b0;
            wait_accept("rst fill");
        end
        reset = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        tests++;
        if (bus.in_ready || bus.blk_valid || bus.blk_words !== '0) begin
            fails++;
            $display("FAIL mid reset: in_ready=%0b blk_valid=%0b w0=%h required 0 0 00000000",
                     bus.in_ready, bus.blk_valid, bus.blk_words[0]);
        end
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        model_push(nblk);
        send_msg("abc after reset", 1'b0, 8'h00);

        repeat (5) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover blocks: got %0d required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
